divider_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits directly downstream of the M-extension decoder and consumes its DIVop and div_valid outputs.
- Operands come from the register-read stage. The result returns to the writeback mux through a valid/ready handshake with the main control FSM.

---
 rtl/divider_unit.sv | 198 +++++++++++++++++++
 tb/tb_divider_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// divider_unit: multi-cycle radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU.
// Optional build macro DIV_EARLY_OUT_EN: when defined, a divisor magnitude
// larger than the dividend magnitude, or a divisor magnitude of one, finishes
// at accept time instead of running all 32 iterations. Results are the same
// either way; only latency changes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for div_valid; operands and op sampled on accept
// CALC  | one restoring step per cycle, 32 steps; div_valid low aborts
// DONE  | result registered; ready pulses in the first cycle, leave when
//       | div_valid drops so the same request is not taken twice

`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 3
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV 3'b100
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 3'b101
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM 3'b110
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 3'b111
`endif

module divider_unit #(
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          dividend,
  input  logic [XLEN-1:0]          divisor,
  input  logic [`DIV_OP_WIDTH-1:0] DIVop,
  input  logic                     div_valid,
  output logic                     div_ready,
  output logic [XLEN-1:0]          div_result,
  output logic                     div_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [4:0]      cnt;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dsr;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic            q_neg;
  logic            r_neg;
  logic            is_rem;

  logic            op_signed;
  logic            op_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            fast;
  logic [XLEN-1:0] fast_q;
  logic [XLEN-1:0] fast_r;
  logic [XLEN-1:0] fast_result;

  logic [XLEN:0]   r_shift;
  logic [XLEN:0]   r_diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;

  assign div_busy = (state != IDLE);

  // Op decode; unknown encodings fall through as DIVU.
  always_comb begin
    op_signed = 1'b0;
    op_rem    = 1'b0;
    case (DIVop)
      `DIV_OP_DIV:  op_signed = 1'b1;
      `DIV_OP_REM:  begin op_signed = 1'b1; op_rem = 1'b1; end
      `DIV_OP_REMU: op_rem = 1'b1;
      default:      ;
    endcase
  end

  assign a_neg = op_signed & dividend[XLEN-1];
  assign b_neg = op_signed & divisor[XLEN-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  // Cases resolved at accept time without iterating.
  always_comb begin
    fast   = 1'b0;
    fast_q = '0;
    fast_r = '0;
    if (divisor == '0) begin
      fast   = 1'b1;
      fast_q = ALL_ONES;
      fast_r = dividend;
    end else if (op_signed && dividend == MIN_NEG && divisor == ALL_ONES) begin
      fast   = 1'b1;
      fast_q = MIN_NEG;
      fast_r = '0;
    end
`ifdef DIV_EARLY_OUT_EN
    else if (b_mag > a_mag) begin
      fast   = 1'b1;
      fast_q = '0;
      fast_r = dividend;
    end else if (b_mag == ONE) begin
      fast   = 1'b1;
      fast_q = (a_neg ^ b_neg) ? -a_mag : a_mag;
      fast_r = '0;
    end
`endif
  end

  assign fast_result = op_rem ? fast_r : fast_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign r_shift  = {rem, dvd[XLEN-1]};
  assign r_diff   = r_shift - {1'b0, dsr};
  assign q_bit    = ~r_diff[XLEN];
  assign rem_next = q_bit ? r_diff[XLEN-1:0] : r_shift[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], q_bit};
  assign q_fin    = q_neg ? -quo_next : quo_next;
  assign r_fin    = r_neg ? -rem_next : rem_next;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dvd        <= '0;
      dsr        <= '0;
      rem        <= '0;
      quo        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      is_rem     <= 1'b0;
      div_result <= '0;
      div_ready  <= 1'b0;
    end else begin
      div_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (div_valid) begin
            dvd    <= a_mag;
            dsr    <= b_mag;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
            is_rem <= op_rem;
            if (fast) begin
              div_result <= fast_result;
              div_ready  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!div_valid) begin
            state <= IDLE;
          end else begin
            dvd <= {dvd[XLEN-2:0], 1'b0};
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              div_result <= is_rem ? r_fin : q_fin;
              div_ready  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (!div_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: the driver pushes expected results and
// latencies, a monitor pops and compares whenever div_ready is seen.

`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 3
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV 3'b100
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 3'b101
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM 3'b110
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 3'b111
`endif

module tb_divider_unit;

  localparam int LAT_FULL = 33;
  localparam int LAT_FAST = 1;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_EARLY = 1;
`else
  localparam int LAT_EARLY = 33;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [31:0]              dividend = '0;
  logic [31:0]              divisor = '0;
  logic [`DIV_OP_WIDTH-1:0] DIVop = '0;
  logic                     div_valid = 1'b0;
  logic                     div_ready;
  logic [31:0]              div_result;
  logic                     div_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] last_exp = '0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  divider_unit #(.XLEN(32)) dut (
    .clk(clk),
    .reset(reset),
    .dividend(dividend),
    .divisor(divisor),
    .DIVop(DIVop),
    .div_valid(div_valid),
    .div_ready(div_ready),
    .div_result(div_result),
    .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every ready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && div_ready) begin
      if (exp_q.size() == 0 || acc_q.size() == 0 || lat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1, expected ready=0 (result 0x%08h)", div_result);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic int l = lat_q.pop_front();
        automatic int a = acc_q.pop_front();
        check("result", div_result, e);
        check("latency", cyc - a + 1, l);
      end
    end
  end

  task automatic run_op(input logic [`DIV_OP_WIDTH-1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int hold);
    int waited;
    @(negedge clk);
    DIVop = op;
    dividend = a;
    divisor = b;
    div_valid = 1'b1;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    last_exp = exp;
    @(posedge clk);
    #1 acc_q.push_back(cyc);
    @(negedge clk);
    check("busy_after_accept", {31'd0, div_busy}, 32'd1);
    waited = 0;
    while (!div_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!div_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ready in 40 cycles, expected ready after %0d", lat);
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
    repeat (hold) @(negedge clk);
    if (hold > 0) check("busy_in_done", {31'd0, div_busy}, 32'd1);
    div_valid = 1'b0;
    @(negedge clk);
    check("busy_back_idle", {31'd0, div_busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_ready", {31'd0, div_ready}, 32'd0);
    check("reset_result", div_result, 32'd0);
    check("reset_busy", {31'd0, div_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(`DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL, 0);
    run_op(`DIV_OP_REMU, 32'd100, 32'd7, 32'd2, LAT_FULL, 0);
    run_op(`DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_FULL, 0);
    run_op(`DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_FULL, 0);
    run_op(`DIV_OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, LAT_FULL, 0);
    run_op(`DIV_OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_FULL, 0);
    run_op(3'b000,       32'd100, 32'd7, 32'd14, LAT_FULL, 0);
    run_op(`DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, LAT_FULL, 0);

    run_op(`DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_FAST, 0);
    run_op(`DIV_OP_REM,  32'h8000_0001, 32'd0, 32'h8000_0001, LAT_FAST, 0);
    run_op(`DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST, 0);
    run_op(`DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_FAST, 0);

    run_op(`DIV_OP_DIVU, 32'd3, 32'd10, 32'd0, LAT_EARLY, 0);
    run_op(`DIV_OP_REMU, 32'd3, 32'd10, 32'd3, LAT_EARLY, 5);
    run_op(`DIV_OP_REM,  32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, LAT_EARLY, 0);
    run_op(`DIV_OP_DIV,  32'd100, 32'hFFFF_FFFF, 32'hFFFF_FF9C, LAT_EARLY, 0);
    run_op(`DIV_OP_REM,  32'd5, 32'hFFFF_FFFF, 32'd0, LAT_EARLY, 0);
    run_op(`DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL, 5);

    // Abort by dropping div_valid part way through CALC.
    @(negedge clk);
    DIVop = `DIV_OP_DIVU;
    dividend = 32'd1000;
    divisor = 32'd3;
    div_valid = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    div_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, div_busy}, 32'd0);
    check("abort_result_held", div_result, last_exp);
    repeat (40) @(negedge clk);
    run_op(`DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL, 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    DIVop = `DIV_OP_DIVU;
    dividend = 32'd77;
    divisor = 32'd5;
    div_valid = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midcalc_reset_ready", {31'd0, div_ready}, 32'd0);
    check("midcalc_reset_result", div_result, 32'd0);
    check("midcalc_reset_busy", {31'd0, div_busy}, 32'd0);
    div_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run_op(`DIV_OP_REMU, 32'd77, 32'd5, 32'd2, LAT_FULL, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
